// File: rtl/aes_pkg.sv
// AES key-schedule shared types, encodings and helper functions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_pkg;

    localparam int WORD_W = 32;
    localparam int RKEY_W = 128;

    localparam logic [1:0] KEY_LEN_128  = 2'd0;
    localparam logic [1:0] KEY_LEN_192  = 2'd1;
    localparam logic [1:0] KEY_LEN_256  = 2'd2;
    localparam logic [1:0] KEY_LEN_RSVD = 2'd3;

    typedef enum logic {
        ST_IDLE,
        ST_EXPAND
    } kx_state_e;

    // Nk: key length in 32-bit words (reserved code maps to 0)
    function automatic logic [3:0] nk_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: nk_of = 4'd4;
            KEY_LEN_192: nk_of = 4'd6;
            KEY_LEN_256: nk_of = 4'd8;
            default:     nk_of = 4'd0;
        endcase
    endfunction

    // Nr = Nk + 6
    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        nr_of = nk_of(key_len) + 4'd6;
    endfunction

    // Total schedule words 4*(Nr+1): 44 / 52 / 60
    function automatic logic [5:0] total_of(input logic [1:0] key_len);
        total_of = {nr_of(key_len) + 4'd1, 2'b00};
    endfunction

    // A key length is usable when it is not reserved and fits the build
    function automatic logic key_len_ok(input logic [1:0] key_len, input int nk_max);
        key_len_ok = (key_len != KEY_LEN_RSVD) && (int'(nk_of(key_len)) <= nk_max);
    endfunction

    // GF(2^8) multiply by x, reducing by the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: S-box applied to each byte of a 32-bit word.
// Latency: combinational.
// Backpressure: n/a.
// Ports: word_in -> word_out.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] word_in,
    output logic [WORD_W-1:0] word_out
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        s_box u_s_box (
            .in_byte  (word_in[8*b +: 8]),
            .out_byte (word_out[8*b +: 8])
        );
    end

endmodule

// File: rtl/s_box.sv
// AES forward S-box, one byte.
// Latency: combinational.
// Backpressure: n/a.
// Ports: in_byte -> out_byte = S(in_byte).
module s_box (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Row r of the table holds S(16r) .. S(16r+15), entry 0 in the MSBs
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] bit_base;

    always_comb begin
        bit_base = 11'd2047 - {in_byte, 3'b000};
        out_byte = SBOX_TBL[bit_base -: 8];
    end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule, one word per cycle, with a round-key read port.
// Latency: done pulses 41/47/53 cycles after the accepting start edge; reads are combinational.
// Backpressure: none; start while busy is dropped, not queued.
// Ports: clk, rst (sync, active-high); start/key_len/key_in request an expansion;
//        busy/done/err/key_valid/num_rounds report status; rd_round -> rd_key reads a round key.
// Optional: define AES_KEYEXP_INV_ORDER_EN to add rd_inv (reverse round order for decryption).
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NK_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [32*NK_MAX-1:0]  key_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  key_valid,
    output logic [3:0]            num_rounds,
    input  logic [3:0]            rd_round,
`ifdef AES_KEYEXP_INV_ORDER_EN
    input  logic                  rd_inv,
`endif
    output logic [RKEY_W-1:0]     rd_key
);

    localparam int DEPTH = 4 * (NK_MAX + 7);
    localparam int KEY_W = 32 * NK_MAX;

    kx_state_e         state_q, state_d;
    logic [WORD_W-1:0] rk_mem [DEPTH];
    logic [5:0]        i_q;        // index of the word being generated
    logic [2:0]        kmod_q;     // i mod Nk, kept as a wrapping counter
    logic [7:0]        rcon_q;
    logic [3:0]        nk_q;
    logic [5:0]        last_q;     // T-1 for the accepted key length
    logic              len_ok;
    logic              accept;
    logic              last_word;

    logic [WORD_W-1:0] prev_w, back_w, sw_in, sw_out, temp_w, new_w;
    logic              rot_point, sub_point;

    assign len_ok    = key_len_ok(key_len, NK_MAX);
    assign accept    = (state_q == ST_IDLE) && start && len_ok;
    assign last_word = (state_q == ST_EXPAND) && (i_q == last_q);
    assign busy      = (state_q == ST_EXPAND);

    // ---------------- word generator ----------------
    assign rot_point = (kmod_q == 3'd0);
    assign sub_point = (nk_q == 4'd8) && (kmod_q == 3'd4);

    always_comb begin
        prev_w = rk_mem[i_q - 6'd1];
        back_w = rk_mem[i_q - {2'b00, nk_q}];
        // One SubWord unit serves both the RotWord step and the Nk=8 mid-key step
        sw_in  = rot_point ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        if (rot_point) begin
            temp_w = sw_out ^ {rcon_q, 24'h0};
        end else if (sub_point) begin
            temp_w = sw_out;
        end else begin
            temp_w = prev_w;
        end
        new_w = back_w ^ temp_w;
    end

    aes_sub_word u_sub_word (
        .word_in  (sw_in),
        .word_out (sw_out)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept)    state_d = ST_EXPAND;
            ST_EXPAND: if (last_word) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // ---------------- datapath / status ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                rk_mem[j] <= '0;
            end
            i_q        <= '0;
            kmod_q     <= '0;
            rcon_q     <= '0;
            nk_q       <= '0;
            last_q     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            key_valid  <= 1'b0;
            num_rounds <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (start && !len_ok) begin
                    err <= 1'b1;
                end else if (accept) begin
                    // Key words are left-aligned in key_in; w[0] sits in the MSBs
                    for (int j = 0; j < NK_MAX; j++) begin
                        if (j < int'(nk_of(key_len))) begin
                            rk_mem[j] <= key_in[KEY_W-1-32*j -: 32];
                        end
                    end
                    nk_q       <= nk_of(key_len);
                    num_rounds <= nr_of(key_len);
                    last_q     <= total_of(key_len) - 6'd1;
                    i_q        <= {2'b00, nk_of(key_len)};
                    kmod_q     <= '0;
                    rcon_q     <= 8'h01;
                    key_valid  <= 1'b0;
                end
            end else begin
                rk_mem[i_q] <= new_w;
                i_q         <= i_q + 6'd1;
                if ({1'b0, kmod_q} == nk_q - 4'd1) begin
                    kmod_q <= '0;
                end else begin
                    kmod_q <= kmod_q + 3'd1;
                end
                if (rot_point) begin
                    rcon_q <= xtime(rcon_q);
                end
                if (last_word) begin
                    done      <= 1'b1;
                    key_valid <= 1'b1;
                end
            end
        end
    end

    // ---------------- read port ----------------
    logic       inv_sel;
    logic [3:0] eff_round;
    logic [5:0] rd_base;
    logic [5:0] rd_idx;

`ifdef AES_KEYEXP_INV_ORDER_EN
    assign inv_sel = rd_inv;
`else
    assign inv_sel = 1'b0;
`endif

    always_comb begin
        eff_round = inv_sel ? (num_rounds - rd_round) : rd_round;
        rd_base   = {eff_round, 2'b00};
        rd_idx    = rd_base;
        rd_key    = '0;
        if (rd_round <= num_rounds) begin
            for (int k = 0; k < 4; k++) begin
                rd_idx = rd_base + 6'(k);
                // The bound only matters for the smaller builds, where round
                // indices above Nr would otherwise address past the buffer
                if (rd_idx < 6'(DEPTH)) begin
                    rd_key[RKEY_W-1-32*k -: 32] = rk_mem[rd_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
module tb_aes_key_expander;

    localparam logic [127:0] K128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K128_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K128_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [191:0] K192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] K192_R12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K256_R1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K256_R14 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy, done, err, key_valid;
    logic [3:0]   num_rounds;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         rd_inv;

    // Narrow build used only for the key-too-long case
    logic         start4;
    logic [1:0]   key_len4;
    logic [127:0] key_in4;
    logic         busy4, done4, err4, key_valid4;
    logic [3:0]   num_rounds4;
    logic [127:0] rd_key4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_key_expander #(.NK_MAX(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_len    (key_len),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .key_valid  (key_valid),
        .num_rounds (num_rounds),
        .rd_round   (rd_round),
`ifdef AES_KEYEXP_INV_ORDER_EN
        .rd_inv     (rd_inv),
`endif
        .rd_key     (rd_key)
    );

    aes_key_expander #(.NK_MAX(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .key_len    (key_len4),
        .key_in     (key_in4),
        .busy       (busy4),
        .done       (done4),
        .err        (err4),
        .key_valid  (key_valid4),
        .num_rounds (num_rounds4),
        .rd_round   (4'd0),
`ifdef AES_KEYEXP_INV_ORDER_EN
        .rd_inv     (1'b0),
`endif
        .rd_key     (rd_key4)
    );

    // Counts cycles from the accepting edge until done is seen (200 = timed out)
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic launch(input logic [1:0] len, input logic [255:0] key);
        key_len = len;
        key_in  = key;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got %b want 0", key_valid); end
        checks++; if (num_rounds !== 4'd0) begin errors++; $display("FAIL reset_num_rounds got %0d want 0", num_rounds); end
        rd_round = 4'd0; #1;
        checks++; if (rd_key !== 128'h0)  begin errors++; $display("FAIL reset_rd_key got %h want 0", rd_key); end
    endtask

    task automatic test_aes128;
        int cyc;
        launch(2'd0, {K128, 128'h0});
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL a128_busy got %b want 1", busy); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL a128_kv_fall got %b want 0", key_valid); end
        checks++; if (num_rounds !== 4'd10) begin errors++; $display("FAIL a128_nr got %0d want 10", num_rounds); end
        wait_done(cyc);
        checks++; if (cyc != 41)          begin errors++; $display("FAIL a128_latency got %0d want 41", cyc); end
        checks++; if (busy !== 1'b0 || key_valid !== 1'b1)
            begin errors++; $display("FAIL a128_status got busy=%b kv=%b want busy=0 kv=1", busy, key_valid); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL a128_done_pulse got %b want 0", done); end
        rd_round = 4'd0; #1;
        checks++; if (rd_key !== K128)    begin errors++; $display("FAIL a128_r0 got %h want %h", rd_key, K128); end
        rd_round = 4'd1; #1;
        checks++; if (rd_key !== K128_R1) begin errors++; $display("FAIL a128_r1 got %h want %h", rd_key, K128_R1); end
        rd_round = 4'd10; #1;
        checks++; if (rd_key !== K128_R10) begin errors++; $display("FAIL a128_r10 got %h want %h", rd_key, K128_R10); end
        rd_round = 4'd11; #1;
        checks++; if (rd_key !== 128'h0)  begin errors++; $display("FAIL a128_r11 got %h want 0", rd_key); end
    endtask

    task automatic test_inv_order;
`ifdef AES_KEYEXP_INV_ORDER_EN
        rd_inv = 1'b1;
        rd_round = 4'd0; #1;
        checks++; if (rd_key !== K128_R10) begin errors++; $display("FAIL inv_r0 got %h want %h", rd_key, K128_R10); end
        rd_round = 4'd10; #1;
        checks++; if (rd_key !== K128)    begin errors++; $display("FAIL inv_r10 got %h want %h", rd_key, K128); end
        rd_round = 4'd11; #1;
        checks++; if (rd_key !== 128'h0)  begin errors++; $display("FAIL inv_r11 got %h want 0", rd_key); end
        rd_inv = 1'b0; #1;
`endif
    endtask

    task automatic test_aes192;
        int cyc;
        launch(2'd1, {K192, 64'h0});
        wait_done(cyc);
        checks++; if (cyc != 47)           begin errors++; $display("FAIL a192_latency got %0d want 47", cyc); end
        checks++; if (num_rounds !== 4'd12) begin errors++; $display("FAIL a192_nr got %0d want 12", num_rounds); end
        rd_round = 4'd12; #1;
        checks++; if (rd_key !== K192_R12) begin errors++; $display("FAIL a192_r12 got %h want %h", rd_key, K192_R12); end
        rd_round = 4'd0; #1;
        checks++; if (rd_key !== K192[191:64]) begin errors++; $display("FAIL a192_r0 got %h want %h", rd_key, K192[191:64]); end
    endtask

    task automatic test_aes256;
        int cyc;
        launch(2'd2, K256);
        wait_done(cyc);
        checks++; if (cyc != 53)           begin errors++; $display("FAIL a256_latency got %0d want 53", cyc); end
        checks++; if (num_rounds !== 4'd14) begin errors++; $display("FAIL a256_nr got %0d want 14", num_rounds); end
        rd_round = 4'd1; #1;
        checks++; if (rd_key !== K256_R1)  begin errors++; $display("FAIL a256_r1 got %h want %h", rd_key, K256_R1); end
        rd_round = 4'd14; #1;
        checks++; if (rd_key !== K256_R14) begin errors++; $display("FAIL a256_r14 got %h want %h", rd_key, K256_R14); end
        rd_round = 4'd15; #1;
        checks++; if (rd_key !== 128'h0)   begin errors++; $display("FAIL a256_r15 got %h want 0", rd_key); end
    endtask

    task automatic test_illegal;
        launch(2'd3, 256'h0);
        checks++; if (err !== 1'b1)  begin errors++; $display("FAIL ill_err got %b want 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ill_busy got %b want 0", busy); end
        @(posedge clk); #1;
        checks++; if (err !== 1'b0)  begin errors++; $display("FAIL ill_err_pulse got %b want 0", err); end
        checks++; if (key_valid !== 1'b1 || num_rounds !== 4'd14)
            begin errors++; $display("FAIL ill_kept got kv=%b nr=%0d want kv=1 nr=14", key_valid, num_rounds); end
        rd_round = 4'd14; #1;
        checks++; if (rd_key !== K256_R14) begin errors++; $display("FAIL ill_r14 got %h want %h", rd_key, K256_R14); end
        // 256-bit key on a 128-bit-only build
        key_len4 = 2'd2;
        key_in4  = K128;
        start4   = 1'b1;
        @(posedge clk); #1;
        start4   = 1'b0;
        checks++; if (err4 !== 1'b1 || busy4 !== 1'b0)
            begin errors++; $display("FAIL nk4_err got err=%b busy=%b want err=1 busy=0", err4, busy4); end
        @(posedge clk); #1;
        checks++; if (err4 !== 1'b0 || num_rounds4 !== 4'd0)
            begin errors++; $display("FAIL nk4_after got err=%b nr=%0d want err=0 nr=0", err4, num_rounds4); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int bad;
        launch(2'd0, {K128, 128'h0});
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            if (cyc == 10) begin
                key_len = 2'd2;
                key_in  = K256;
                start   = 1'b1;
            end else begin
                start   = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        checks++; if (cyc != 41)           begin errors++; $display("FAIL b2b_latency got %0d want 41", cyc); end
        checks++; if (num_rounds !== 4'd10) begin errors++; $display("FAIL b2b_nr got %0d want 10", num_rounds); end
        rd_round = 4'd10; #1;
        checks++; if (rd_key !== K128_R10) begin errors++; $display("FAIL b2b_r10 got %h want %h", rd_key, K128_R10); end

        // New expansion, then reset part-way through
        launch(2'd1, {K192, 64'h0});
        cyc = 1;
        while (cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || key_valid !== 1'b0)
            begin errors++; $display("FAIL rst_mid got busy=%b kv=%b want 0 0", busy, key_valid); end
        bad = 0;
        for (int r = 0; r < 16; r++) begin
            rd_round = 4'(r); #1;
            if (rd_key !== 128'h0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_rd_zero got %0d nonzero rounds want 0", bad); end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        key_len  = 2'd0;
        key_in   = '0;
        rd_round = 4'd0;
        rd_inv   = 1'b0;
        start4   = 1'b0;
        key_len4 = 2'd0;
        key_in4  = '0;
        test_reset();
        test_aes128();
        test_inv_order();
        test_aes192();
        test_aes256();
        test_illegal();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
Iterative, multi-key-length AES key schedule. It replaces the single-round combinational round-key step with a sequential engine.
- Accepts a 128/192/256-bit cipher key and generates one 32-bit schedule word per cycle.
- Stores the full schedule in an internal round-key buffer.
- Serves any round key through a combinational read port to the cipher datapath.

Parameters:
- NK_MAX, default 8, largest supported key length in 32-bit words. Legal values are 4, 6, 8. It sizes key_in and sets the buffer depth to 4*(NK_MAX+7) words.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request expansion of key_in; sampled only in IDLE
- key_len  input  2  key-length code: 0=128, 1=192, 2=256, 3=reserved
- key_in  input  32*NK_MAX  cipher key. w[0] = key_in[MSB -: 32]; shorter keys are left-aligned, and unused LSBs are ignored.
- busy  output  1  expansion in progress
- done  output  1  one-cycle pulse: schedule complete
- err  output  1  one-cycle pulse: illegal key_len, or key_len exceeds NK_MAX
- key_valid  output  1  buffer holds a complete schedule for the last accepted key
- num_rounds  output  4  Nr of the last accepted key (10/12/14)
- rd_round  input  4  round index to read
- rd_key  output  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]} for r = rd_round

Behaviour:
- On reset, all of these are 0: busy, done, err, key_valid, num_rounds, the buffer, the word counter and the FSM state (IDLE). rst overrides everything, including mid-expansion; the partial schedule is discarded.
- Key-length constants: Nk is 4/6/8 and Nr = Nk+6. Total words T = 4*(Nr+1), giving 44/52/60.
- FSM states: IDLE, EXPAND.
- IDLE handling of start:
  - If key_len is illegal, the block pulses err on the next cycle and stays in IDLE. key_valid and the buffer are unchanged.
  - If key_len is legal, the block writes w[0..Nk-1] from key_in at the sampling edge and latches Nk/Nr. It sets i=Nk and rcon=0x01, and enters EXPAND with busy=1. key_valid falls to 0 in the same cycle.
- EXPAND, one word per cycle:
  - temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon). RotWord is a left byte rotate; xtime wraps 0x80 to 0x1B.
  - Else if Nk==8 and i mod Nk == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp; then i++.
- Track i mod Nk with a separate wrapping counter, not a divider.
- Termination: when w[T-1] is written, the next cycle has busy=0, done=1 and key_valid=1, and the FSM returns to IDLE.
- Latency from the accepting start edge to done is T-Nk+1 cycles: 41 / 47 / 53.
- start while busy is ignored (not queued). start in the done cycle is accepted normally.
- rd_key is a combinational mux over the buffer:
  - When rd_round > num_rounds, rd_key = 0.
  - Contents are defined only while key_valid=1. Reads during EXPAND return partially written data.
- num_rounds updates at acceptance and holds until the next accepted start or rst.

Optional Feature:
- AES_KEYEXP_INV_ORDER_EN: adds input rd_inv (1 bit). When rd_inv=1, rd_key returns round num_rounds-rd_round, which supports decryption without address arithmetic in the cipher. The out-of-range rule still applies to rd_round.
- Without the macro, the port does not exist and the read order is always forward.

Decomposition:
- Package aes_pkg holds:
  - key_len encodings;
  - nk_of()/nr_of() lookup functions;
  - the xtime function;
  - word and round-key widths.
- One sub-module, aes_sub_word: four instances of the existing s_box that apply SubWord to a 32-bit word. It is purely combinational and is shared by the RotWord and Nk==8 paths via an input mux.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
  - done 41 cycles after start;
  - rd_round=0 returns the key;
  - rd_round=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6;
  - num_rounds=10.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done after 47 cycles;
  - rd_round=12 returns e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done after 53 cycles;
  - rd_round=14 returns fe4890d1e6188d0b046df344706c631e;
  - rd_round=15 returns 0.
- key_len=3, or key_len=2 with NK_MAX=4:
  - err pulses once;
  - busy stays 0;
  - prior schedule still readable with key_valid=1.
- Second start at cycle 10 of an expansion is ignored, and the result matches the first key. Then rst at cycle 20 of a new expansion gives busy=0, key_valid=0, and rd_key=0 for all rounds.
- With AES_KEYEXP_INV_ORDER_EN on the AES-128 vector: rd_inv=1, rd_round=0 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
